ccip_mmio_fifo: RTL and testbench

// - Parametrised MMIO-mapped FIFO for AFU user register space, behind the CCI-P MMIO decode.
// - Host MMIO write to DATA pushes an entry; host MMIO read of DATA pops the head.
// - Adds STATUS (count/flags/sticky errors) and CTRL (flush, clear errors) registers.
// - Read responses are registered, one per request, with the request TID echoed back.

---
 rtl/ccip_mmio_fifo.sv | 125 ++++++++++++
 tb/tb_ccip_mmio_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ccip_mmio_fifo.sv
// MMIO-mapped FIFO: DATA push/pop, STATUS, CTRL registers with registered read responses.
// Define MMIO_FIFO_PEEK_EN to map a non-popping head read at BASE_ADDR+6.
module ccip_mmio_fifo #(
  parameter int unsigned  DATA_W    = 64,
  parameter int unsigned  DEPTH     = 8,
  parameter logic [15:0]  BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_addr,
  input  logic [8:0]  rd_tid,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        hit
);

  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam logic [15:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd2;
  localparam logic [15:0] CTRL_ADDR   = BASE_ADDR + 16'd4;
`ifdef MMIO_FIFO_PEEK_EN
  localparam logic [15:0] PEEK_ADDR   = BASE_ADDR + 16'd6;
  localparam logic [15:0] LAST_ADDR   = PEEK_ADDR;
`else
  localparam logic [15:0] LAST_ADDR   = CTRL_ADDR;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic              overflow, underflow;

  logic empty, full;
  logic push_req, pop_req, do_push, do_pop;
  logic flush, clr_err, ovf_evt, unf_evt;
  logic [63:0] head, status, rd_mux;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign push_req = wr_valid && (wr_addr == DATA_ADDR);
  assign pop_req  = rd_valid && (rd_addr == DATA_ADDR);
  assign flush    = wr_valid && (wr_addr == CTRL_ADDR) && wr_data[0];
  assign clr_err  = wr_valid && (wr_addr == CTRL_ADDR) && wr_data[1];
  assign do_pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is accepted.
  assign do_push  = push_req && (!full || do_pop);
  assign ovf_evt  = push_req && full && !do_pop;
  assign unf_evt  = pop_req && empty;

  assign hit = (rd_addr >= BASE_ADDR) && (rd_addr <= LAST_ADDR);

  always_comb begin
    head = '0;
    head[DATA_W-1:0] = mem[rd_ptr];
  end

  assign status = {32'(DEPTH), 12'h000, underflow, overflow, full, empty, 16'(count)};

  always_comb begin
    rd_mux = '0;
    if (rd_addr == DATA_ADDR) begin
      rd_mux = empty ? '0 : head;
    end else if (rd_addr == STATUS_ADDR) begin
      rd_mux = status;
`ifdef MMIO_FIFO_PEEK_EN
    end else if (rd_addr == PEEK_ADDR) begin
      rd_mux = empty ? '0 : head;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_valid;
      if (rd_valid) begin
        rsp_tid  <= rd_tid;
        rsp_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_ccip_mmio_fifo.sv
// Directed self-checking bench for ccip_mmio_fifo (DEPTH=8, DATA_W=64, BASE=0x20).
module tb_ccip_mmio_fifo;

  localparam logic [15:0] A_DATA   = 16'h0020;
  localparam logic [15:0] A_STATUS = 16'h0022;
  localparam logic [15:0] A_CTRL   = 16'h0024;
  localparam logic [15:0] A_PEEK   = 16'h0026;
  localparam logic [63:0] ST_EMPTY = 64'h0000_0008_0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [8:0]  rd_tid = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        hit;

  int vectors = 0;
  int miscompares = 0;
  logic        s_hit;
  logic [63:0] s_data;

  ccip_mmio_fifo #(.DATA_W(64), .DEPTH(8), .BASE_ADDR(16'h0020)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tid(rd_tid),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle with optional write and read; response captured #1 after the edge.
  task automatic op(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                    input logic rv, input logic [15:0] ra, input logic [8:0] tid);
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rd_tid = tid;
    #1 s_hit = hit;
    @(posedge clk);
    #1;
    s_data = rsp_data;
    if (rv) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_tid", 64'(rsp_tid), 64'(tid));
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    op(1'b1, a, d, 1'b0, '0, '0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [8:0] tid,
                        input logic [63:0] exp);
    op(1'b0, '0, '0, 1'b1, a, tid);
    chk(tag, s_data, exp);
  endtask

  initial begin
    // T1: reset values and STATUS after reset, single-cycle response pulse
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_tid", 64'(rsp_tid), 64'd0);
    chk("reset rsp_data", rsp_data, 64'd0);
    @(negedge clk) rst = 1'b0;
    rd_chk("t1 status", A_STATUS, 9'h001, ST_EMPTY);
    chk("t1 hit status", 64'(s_hit), 64'd1);
    @(posedge clk);
    #1 chk("t1 pulse width", 64'(rsp_valid), 64'd0);

    // T2: fill, drain in order
    for (int i = 0; i < 8; i++) wr(A_DATA, 64'h11 + 64'(i));
    rd_chk("t2 status full", A_STATUS, 9'h002, 64'h0000_0008_0002_0008);
    for (int i = 0; i < 8; i++) rd_chk("t2 pop", A_DATA, 9'(9'h100 + i), 64'h11 + 64'(i));
    rd_chk("t2 status empty", A_STATUS, 9'h003, ST_EMPTY);

    // T3: overflow, underflow, clear
    for (int i = 0; i < 8; i++) wr(A_DATA, 64'h21 + 64'(i));
    wr(A_DATA, 64'hDEAD);
    rd_chk("t3 status ovf", A_STATUS, 9'h004, 64'h0000_0008_0006_0008);
    for (int i = 0; i < 8; i++) rd_chk("t3 pop", A_DATA, 9'(i), 64'h21 + 64'(i));
    rd_chk("t3 pop empty", A_DATA, 9'h1FF, 64'd0);
    rd_chk("t3 status flags", A_STATUS, 9'h005, 64'h0000_0008_000D_0000);
    wr(A_CTRL, 64'd2);
    rd_chk("t3 status cleared", A_STATUS, 9'h006, ST_EMPTY);

    // T4: simultaneous push/pop on full, then on empty
    for (int i = 0; i < 8; i++) wr(A_DATA, 64'h31 + 64'(i));
    op(1'b1, A_DATA, 64'hAA, 1'b1, A_DATA, 9'h010);
    chk("t4 full pushpop", s_data, 64'h31);
    rd_chk("t4 status full", A_STATUS, 9'h011, 64'h0000_0008_0002_0008);
    for (int i = 1; i < 8; i++) rd_chk("t4 drain", A_DATA, 9'h012, 64'h31 + 64'(i));
    rd_chk("t4 drain pushed", A_DATA, 9'h013, 64'hAA);
    op(1'b1, A_DATA, 64'hAA, 1'b1, A_DATA, 9'h014);
    chk("t4 empty pushpop", s_data, 64'd0);
    rd_chk("t4 status unf", A_STATUS, 9'h015, 64'h0000_0008_0008_0001);
    wr(A_CTRL, 64'd3);
    rd_chk("t4 flush clear", A_STATUS, 9'h016, ST_EMPTY);

    // T5: flush with pop returns old head; pointer wrap keeps order
    for (int i = 0; i < 3; i++) wr(A_DATA, 64'h41 + 64'(i));
    op(1'b1, A_CTRL, 64'd1, 1'b1, A_DATA, 9'h020);
    chk("t5 flush pop", s_data, 64'h41);
    rd_chk("t5 status after flush", A_STATUS, 9'h021, ST_EMPTY);
    for (int i = 0; i < 20; i++) begin
      wr(A_DATA, 64'h500 + 64'(i));
      if (i >= 3) rd_chk("t5 wrap", A_DATA, 9'h022, 64'h500 + 64'(i - 3));
    end
    for (int i = 17; i < 20; i++) rd_chk("t5 wrap tail", A_DATA, 9'h023, 64'h500 + 64'(i));
    rd_chk("t5 status end", A_STATUS, 9'h024, ST_EMPTY);

    // T6: peek window
`ifdef MMIO_FIFO_PEEK_EN
    wr(A_DATA, 64'd5);
    wr(A_DATA, 64'd6);
    rd_chk("t6 peek1", A_PEEK, 9'h030, 64'd5);
    chk("t6 peek hit", 64'(s_hit), 64'd1);
    rd_chk("t6 peek2", A_PEEK, 9'h031, 64'd5);
    rd_chk("t6 status", A_STATUS, 9'h032, 64'h0000_0008_0000_0002);
    rd_chk("t6 pop5", A_DATA, 9'h033, 64'd5);
    rd_chk("t6 pop6", A_DATA, 9'h034, 64'd6);
    rd_chk("t6 peek empty", A_PEEK, 9'h035, 64'd0);
    rd_chk("t6 no unf", A_STATUS, 9'h036, ST_EMPTY);
`else
    wr(A_DATA, 64'd5);
    rd_chk("t6 unmapped peek", A_PEEK, 9'h030, 64'd0);
    chk("t6 peek no hit", 64'(s_hit), 64'd0);
    rd_chk("t6 status", A_STATUS, 9'h031, 64'h0000_0008_0000_0001);
    rd_chk("t6 pop5", A_DATA, 9'h032, 64'd5);
`endif
    rd_chk("unmapped ctrl", A_CTRL, 9'h040, 64'd0);
    chk("ctrl hit", 64'(s_hit), 64'd1);
    rd_chk("unmapped low", 16'h001F, 9'h041, 64'd0);
    chk("low no hit", 64'(s_hit), 64'd0);

    // Reset mid-operation
    wr(A_DATA, 64'h77);
    wr(A_DATA, 64'h78);
    @(negedge clk) rst = 1'b1;
    #1 chk("midreset rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk) rst = 1'b0;
    rd_chk("midreset status", A_STATUS, 9'h050, ST_EMPTY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
